// File: rtl/param_dual_rom_pkg.sv
// Shared ROM contents for the dual-port lookup: base words, fill pattern
// and the word_at() content function used by both read ports.
package param_dual_rom_pkg;

   localparam logic [15:0] XOR_PAT = 16'hA5A5;

   localparam logic [15:0] BASE_WORD [8] = '{
      16'hAAAA, 16'hABCD, 16'h9999, 16'h2121,
      16'h8585, 16'h4258, 16'h7B4E, 16'h9A2B
   };

   typedef struct packed {
      logic valid;
      logic err;
   } rd_status_t;

   // Returns the 32-bit zero-extended content of word idx; callers keep the LSBs.
   function automatic logic [31:0] word_at(input logic [31:0] idx);
      if (idx < 32'd8) begin
         word_at = {16'h0000, BASE_WORD[idx[2:0]]};
      end else begin
         word_at = idx ^ {16'h0000, XOR_PAT};
      end
   endfunction

endpackage

// File: rtl/rom_read_port.sv
// One ROM read port: lookup with out-of-range flag, 1- or 2-stage read
// pipeline and a saturating request counter.
module rom_read_port
   import param_dual_rom_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int DEPTH   = 8,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_cnt,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              err,
   output logic [CNT_W-1:0]  cnt
);

   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              oob;
   logic [DATA_W-1:0] lookup;
   logic [DATA_W-1:0] s1_data;
   rd_status_t        s1_stat;

   always_comb begin
      oob    = ({1'b0, addr} >= DEPTH_L);
      lookup = oob ? '0 : DATA_W'(word_at(32'(addr)));
   end

   // Data registers only load on a request so outputs hold between results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data <= '0;
         s1_stat <= '0;
      end else begin
         s1_stat.valid <= en;
         s1_stat.err   <= en & oob;
         if (en) s1_data <= lookup;
      end
   end

   generate
      if (LATENCY == 2) begin : g_lat2
         logic [DATA_W-1:0] s2_data;
         rd_status_t        s2_stat;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_data <= '0;
               s2_stat <= '0;
            end else begin
               s2_stat <= s1_stat;
               if (s1_stat.valid) s2_data <= s1_data;
            end
         end

         assign data  = s2_data;
         assign valid = s2_stat.valid;
         assign err   = s2_stat.err;
      end else begin : g_lat1
         assign data  = s1_data;
         assign valid = s1_stat.valid;
         assign err   = s1_stat.err;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr_cnt) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/param_dual_rom.sv
// Parameterized dual-port read-only memory; two independent read ports
// sharing one content function and a common counter clear.
module param_dual_rom
   import param_dual_rom_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int DEPTH   = 8,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_en,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic              b_en,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic              clr_cnt,
   output logic [DATA_W-1:0] a_data,
   output logic              a_valid,
   output logic              a_err,
   output logic [CNT_W-1:0]  a_cnt,
   output logic [DATA_W-1:0] b_data,
   output logic              b_valid,
   output logic              b_err,
   output logic [CNT_W-1:0]  b_cnt
);

   rom_read_port #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH),
      .LATENCY(LATENCY), .CNT_W (CNT_W)
   ) u_port_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_cnt(clr_cnt),
      .en     (a_en),
      .addr   (a_addr),
      .data   (a_data),
      .valid  (a_valid),
      .err    (a_err),
      .cnt    (a_cnt)
   );

   rom_read_port #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH),
      .LATENCY(LATENCY), .CNT_W (CNT_W)
   ) u_port_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_cnt(clr_cnt),
      .en     (b_en),
      .addr   (b_addr),
      .data   (b_data),
      .valid  (b_valid),
      .err    (b_err),
      .cnt    (b_cnt)
   );

endmodule

// File: tb/tb_param_dual_rom.sv
// Directed bench for param_dual_rom: defaults, a LATENCY=2/DEPTH=12/CNT_W=3
// variant and a DATA_W=8 variant, all driven from shared stimulus.
module tb_param_dual_rom;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       a_en = 1'b0;
   logic       b_en = 1'b0;
   logic       clr_cnt = 1'b0;
   logic [3:0] a_addr = 4'd0;
   logic [3:0] b_addr = 4'd0;

   int total = 0;
   int passed = 0;

   logic [15:0] d0_a_data, d0_b_data;
   logic        d0_a_valid, d0_b_valid, d0_a_err, d0_b_err;
   logic [7:0]  d0_a_cnt, d0_b_cnt;

   logic [15:0] d1_a_data, d1_b_data;
   logic        d1_a_valid, d1_b_valid, d1_a_err, d1_b_err;
   logic [2:0]  d1_a_cnt, d1_b_cnt;

   logic [7:0]  d2_a_data, d2_b_data;
   logic        d2_a_valid, d2_b_valid, d2_a_err, d2_b_err;
   logic [7:0]  d2_a_cnt, d2_b_cnt;

   logic [15:0] words [8] = '{16'hAAAA, 16'hABCD, 16'h9999, 16'h2121,
                              16'h8585, 16'h4258, 16'h7B4E, 16'h9A2B};

   always #5 clk = ~clk;

   param_dual_rom dut0 (
      .clk(clk), .rst_n(rst_n),
      .a_en(a_en), .a_addr(a_addr[2:0]), .b_en(b_en), .b_addr(b_addr[2:0]),
      .clr_cnt(clr_cnt),
      .a_data(d0_a_data), .a_valid(d0_a_valid), .a_err(d0_a_err), .a_cnt(d0_a_cnt),
      .b_data(d0_b_data), .b_valid(d0_b_valid), .b_err(d0_b_err), .b_cnt(d0_b_cnt)
   );

   param_dual_rom #(.ADDR_W(4), .DEPTH(12), .LATENCY(2), .CNT_W(3)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .a_en(a_en), .a_addr(a_addr), .b_en(b_en), .b_addr(b_addr),
      .clr_cnt(clr_cnt),
      .a_data(d1_a_data), .a_valid(d1_a_valid), .a_err(d1_a_err), .a_cnt(d1_a_cnt),
      .b_data(d1_b_data), .b_valid(d1_b_valid), .b_err(d1_b_err), .b_cnt(d1_b_cnt)
   );

   param_dual_rom #(.DATA_W(8)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .a_en(a_en), .a_addr(a_addr[2:0]), .b_en(b_en), .b_addr(b_addr[2:0]),
      .clr_cnt(clr_cnt),
      .a_data(d2_a_data), .a_valid(d2_a_valid), .a_err(d2_a_err), .a_cnt(d2_a_cnt),
      .b_data(d2_b_data), .b_valid(d2_b_valid), .b_err(d2_b_err), .b_cnt(d2_b_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      #2 rst_n = 1'b0;
      tick();
      check("rst_d0_a_data",  32'(d0_a_data), 32'h0);
      check("rst_d0_a_valid", 32'(d0_a_valid), 32'h0);
      check("rst_d0_b_err",   32'(d0_b_err), 32'h0);
      check("rst_d0_a_cnt",   32'(d0_a_cnt), 32'h0);
      check("rst_d1_b_data",  32'(d1_b_data), 32'h0);
      check("rst_d1_b_valid", 32'(d1_b_valid), 32'h0);
      rst_n = 1'b1;

      // first edge after release: both ports, addresses 1 and 6
      a_addr = 4'd1; b_addr = 4'd6; a_en = 1'b1; b_en = 1'b1;
      tick();
      a_en = 1'b0; b_en = 1'b0;
      check("d0_a_data_1",  32'(d0_a_data), 32'hABCD);
      check("d0_b_data_6",  32'(d0_b_data), 32'h7B4E);
      check("d0_a_valid_1", 32'(d0_a_valid), 32'h1);
      check("d0_b_valid_1", 32'(d0_b_valid), 32'h1);
      check("d0_a_err_1",   32'(d0_a_err), 32'h0);
      check("d0_b_err_1",   32'(d0_b_err), 32'h0);
      check("d2_a_data_8b", 32'(d2_a_data), 32'hCD);
      check("d2_b_data_8b", 32'(d2_b_data), 32'h4E);
      check("d1_a_valid_early", 32'(d1_a_valid), 32'h0);
      tick();
      check("d0_a_valid_idle", 32'(d0_a_valid), 32'h0);
      check("d0_a_data_hold",  32'(d0_a_data), 32'hABCD);
      check("d1_a_valid_lat2", 32'(d1_a_valid), 32'h1);
      check("d1_a_data_lat2",  32'(d1_a_data), 32'hABCD);
      check("d1_b_data_lat2",  32'(d1_b_data), 32'h7B4E);

      // back-to-back stream of addresses 0..7 on port A
      for (int i = 0; i < 8; i++) begin
         a_addr = 4'(i); a_en = 1'b1;
         tick();
         check($sformatf("d0_stream_%0d", i), 32'(d0_a_data), 32'(words[i]));
         check($sformatf("d0_stream_v_%0d", i), 32'(d0_a_valid), 32'h1);
         if (i == 0) begin
            check("d1_stream_v_0", 32'(d1_a_valid), 32'h0);
         end else begin
            check($sformatf("d1_stream_%0d", i - 1), 32'(d1_a_data), 32'(words[i - 1]));
            check($sformatf("d1_stream_v_%0d", i - 1), 32'(d1_a_valid), 32'h1);
         end
      end
      a_en = 1'b0;
      tick();
      check("d1_stream_7",   32'(d1_a_data), 32'h9A2B);
      check("d1_stream_v_7", 32'(d1_a_valid), 32'h1);
      tick();
      check("d1_stream_end", 32'(d1_a_valid), 32'h0);
      check("d0_a_cnt_9",    32'(d0_a_cnt), 32'd9);
      check("d1_a_cnt_sat",  32'(d1_a_cnt), 32'd7);

      // extended depth and out-of-range address on the LATENCY=2 instance
      a_addr = 4'd10; a_en = 1'b1;
      tick();
      a_addr = 4'd13;
      tick();
      a_en = 1'b0;
      check("d1_addr10_data",  32'(d1_a_data), 32'hA5AF);
      check("d1_addr10_valid", 32'(d1_a_valid), 32'h1);
      check("d1_addr10_err",   32'(d1_a_err), 32'h0);
      tick();
      check("d1_addr13_data",  32'(d1_a_data), 32'h0);
      check("d1_addr13_valid", 32'(d1_a_valid), 32'h1);
      check("d1_addr13_err",   32'(d1_a_err), 32'h1);
      tick();
      check("d1_err_idle", 32'(d1_a_err), 32'h0);

      // counter saturation and clear priority
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("d0_b_cnt_clr", 32'(d0_b_cnt), 32'd0);
      b_addr = 4'd2; b_en = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      check("d1_b_cnt_sat", 32'(d1_b_cnt), 32'd7);
      check("d0_b_cnt_9",   32'(d0_b_cnt), 32'd9);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("d1_b_cnt_clr_pri", 32'(d1_b_cnt), 32'd0);
      check("d0_b_cnt_clr_pri", 32'(d0_b_cnt), 32'd0);
      tick();
      b_en = 1'b0;
      check("d1_b_cnt_after", 32'(d1_b_cnt), 32'd1);
      tick();
      tick();

      // reset in the middle of a LATENCY=2 read
      a_addr = 4'd3; a_en = 1'b1;
      tick();
      a_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_d1_a_valid", 32'(d1_a_valid), 32'h0);
      check("midrst_d1_a_data",  32'(d1_a_data), 32'h0);
      check("midrst_d1_a_cnt",   32'(d1_a_cnt), 32'h0);
      check("midrst_d0_a_data",  32'(d0_a_data), 32'h0);
      #2 rst_n = 1'b1;
      tick();
      check("postrst_d1_valid_1", 32'(d1_a_valid), 32'h0);
      tick();
      check("postrst_d1_valid_2", 32'(d1_a_valid), 32'h0);
      check("postrst_d1_data",    32'(d1_a_data), 32'h0);
      check("postrst_d1_err",     32'(d1_a_err), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
